// File: rtl/mono_scanout.sv
// mono_scanout -- framebuffer sink and serial 1bpp CRT scanout.
//
// Stores 16-pixel words from the dithered mono stream into an on-chip
// WIDTH x HEIGHT framebuffer and scans it out MSB-first as one pixel per clock
// with active-low syncs. Every output for counter position (h,v) appears
// exactly three clocks after the counters hold (h,v).
//
// Ports:
//   clk, reset_n              pixel clock, async active-low reset
//   mono_bits[15:0]           pixel word, bit 15 = leftmost, 1 = white
//   mono_xaddr/yaddr[11:0]    position of bit 15 (xaddr[3:0] ignored)
//   mono_bits_ready           1-clk write strobe, one word per clock max
//   mono_vsync                1-clk source frame-start strobe
//   video_pixel               serial pixel, forced 0 outside active area
//   video_hsync_n/vsync_n     active-low syncs
//   video_de                  active-area enable
//   frame_start               1-clk strobe aligned with pixel (0,0)
//
// Build option: define FRAME_LOCK_EN to make mono_vsync reload the raster
// counters to (h=0, v=V_LOCK_LINE); otherwise mono_vsync is ignored.
`timescale 1ns/1ps
module mono_scanout #(
  parameter int WIDTH        = 512,
  parameter int HEIGHT       = 342,
  parameter int H_TOTAL      = 704,
  parameter int H_SYNC_START = 528,
  parameter int H_SYNC_END   = 608,
  parameter int V_TOTAL      = 370,
  parameter int V_SYNC_START = 342,
  parameter int V_SYNC_END   = 346,
  parameter int V_LOCK_LINE  = 342
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mono_bits,
  input  logic [11:0] mono_xaddr,
  input  logic [11:0] mono_yaddr,
  input  logic        mono_bits_ready,
  input  logic        mono_vsync,
  output logic        video_pixel,
  output logic        video_hsync_n,
  output logic        video_vsync_n,
  output logic        video_de,
  output logic        frame_start
);

  localparam int WORDS = WIDTH / 16;
  localparam int XB    = $clog2(WIDTH);
  localparam int WB    = XB - 4;           // word-in-line bits (WIDTH >= 32)
  localparam int YB    = $clog2(HEIGHT);
  localparam int AW    = YB + WB;
  localparam int DEPTH = HEIGHT * WORDS;
  localparam int HB    = $clog2(H_TOTAL);
  localparam int VB    = $clog2(V_TOTAL);

  // raster counters
  logic [HB-1:0] h;
  logic [VB-1:0] v;
  logic          h_last, v_last;

  assign h_last = (h == HB'(H_TOTAL - 1));
  assign v_last = (v == VB'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h <= '0;
      v <= '0;
    end
`ifdef FRAME_LOCK_EN
    // a source frame start outranks a counter wrap in the same clock
    else if (mono_vsync) begin
      h <= '0;
      v <= VB'(V_LOCK_LINE);
    end
`endif
    else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

`ifndef FRAME_LOCK_EN
  logic unused_vsync;
  assign unused_vsync = mono_vsync;
`endif
  logic unused_xlow;
  assign unused_xlow = ^mono_xaddr[3:0];

  // stage 0: timing decode at the counters
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } ctl_t;

  ctl_t ctl0;
  logic rd_en;

  always_comb begin
    ctl0    = '0;
    ctl0.de = (int'(h) < WIDTH) && (int'(v) < HEIGHT);
    ctl0.hs = (int'(h) >= H_SYNC_START) && (int'(h) < H_SYNC_END);
    ctl0.vs = (int'(v) >= V_SYNC_START) && (int'(v) < V_SYNC_END);
    ctl0.fs = (h == '0) && (v == '0);
  end

  assign rd_en = ctl0.de && (h[3:0] == 4'd0);

  // framebuffer: one write and one read port, read sees pre-write data
  logic          wr_en;
  logic [AW-1:0] waddr, raddr;
  logic [15:0]   mem [DEPTH];
  logic [15:0]   rd_word;

  assign wr_en = mono_bits_ready && (int'(mono_xaddr) < WIDTH) &&
                 (int'(mono_yaddr) < HEIGHT);
  assign waddr = {mono_yaddr[YB-1:0], mono_xaddr[XB-1:4]};
  assign raddr = {v[YB-1:0], h[XB-1:4]};

  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= mono_bits;
    if (rd_en) rd_word <= mem[raddr];
  end

  // stage 1: RAM data returns; stage 2: shift register; stage 3: outputs.
  // ctl_pipe carries timing alongside so syncs/de stay aligned to pixels.
  ctl_t [1:0]  ctl_pipe;
  logic        load1;
  logic [15:0] shreg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl_pipe      <= '0;
      load1         <= 1'b0;
      shreg         <= '0;
      video_pixel   <= 1'b0;
      video_hsync_n <= 1'b1;
      video_vsync_n <= 1'b1;
      video_de      <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      ctl_pipe[0]   <= ctl0;
      load1         <= rd_en;
      ctl_pipe[1]   <= ctl_pipe[0];
      // reload replaces the shift on a word boundary, so words abut seamlessly
      shreg         <= load1 ? rd_word : {shreg[14:0], 1'b0};
      video_de      <= ctl_pipe[1].de;
      video_pixel   <= ctl_pipe[1].de & shreg[15];
      video_hsync_n <= ~ctl_pipe[1].hs;
      video_vsync_n <= ~ctl_pipe[1].vs;
      frame_start   <= ctl_pipe[1].fs;
    end
  end

endmodule
